// File: rtl/seg7_scan_if.sv
// Register-write port and display pins of the seven-segment scan controller.
// The master drives digit writes; the slave (the controller) drives the pins.
interface seg7_scan_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [5:0] wr_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] scan_idx;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  an, seg, dp, scan_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output an, seg, dp, scan_idx
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// Four-digit seven-segment scanner: holds per-digit values written by the CPU and
// lights one anode at a time, with an all-dark gap between digits against ghosting.
module seg7_scan_controller #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int GAP_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       reset,
  seg7_scan_if.slave bus
);

  localparam int MAX_CYCLES = (REFRESH_CYCLES > GAP_CYCLES) ? REFRESH_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [5:0] DIGIT_BLANK = 6'b10_0000;

  typedef enum logic {
    ST_GAP,
    ST_SHOW
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [5:0]       digit [4];
  logic [5:0]       shown;

  logic [3:0] an_p1, an_nxt;
  logic [6:0] seg_p1, seg_nxt;
  logic       dp_p1, dp_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan sequencing: GAP and SHOW share one cycle counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    case (state)
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: begin
        state_nxt = ST_GAP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pins follow the upcoming state so the lit window lines up with the FSM, while
  // the digit value is the one held before the edge (a write shows one edge later).
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    shown   = digit[idx_nxt];
    if (state_nxt == ST_SHOW) begin
      an_nxt = ~(4'b0001 << idx_nxt);
      if (!shown[5]) begin
        seg_nxt = hex_to_seg(shown[3:0]);
        dp_nxt  = ~shown[4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        digit[i] <= DIGIT_BLANK;
      end
    end else if (bus.wr_en) begin
      digit[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_GAP;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_p1  <= 4'b1111;
      seg_p1 <= 7'b1111111;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= an_nxt;
      seg_p1 <= seg_nxt;
      dp_p1  <= dp_nxt;
    end
  end

  assign bus.an       = an_p1;
  assign bus.seg      = seg_p1;
  assign bus.dp       = dp_p1;
  assign bus.scan_idx = idx;

endmodule
